servo_ramp_scheduler: RTL and testbench

SERVO_RAMP_SCHEDULER -- requirements
Module: servo_ramp_scheduler

---
 rtl/servo_pkg.sv | 24 ++
 rtl/servo_ramp_scheduler_gray2bin.sv | 22 ++
 rtl/servo_ramp_scheduler.sv | 174 +++++++++++++++++
 tb/tb_servo_ramp_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pkg
//  Description : Shared definitions for the servo ramp scheduler: default
//                datapath width, compare-value limits and FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

  localparam int W_DEFAULT = 8;

  // PWM compare limits; a lane is never driven outside [MIN_CVR, MAX_CVR]
  // once INIT has run, so the PWM never reaches 0 % or 100 % duty.
  localparam logic [7:0] MAX_CVR = 8'hFE;
  localparam logic [7:0] MIN_CVR = 8'h01;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    SWEEP = 2'd2
  } state_t;

endpackage : servo_pkg
`default_nettype wire

// File: rtl/servo_ramp_scheduler_gray2bin.sv
`default_nettype none
// ============================================================================
//  Module      : gray2bin
//  Description : Combinational Gray-code to binary converter. Binary bit i is
//                the XOR reduction of all Gray bits from the MSB down to i.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray2bin #(
  parameter int W = 8
) (
  input  logic [W-1:0] gray_in,
  output logic [W-1:0] bin_out
);

  // Each output bit is computed from the inputs only, so there is no ripple
  // through other output bits.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_out[i] = ^gray_in[W-1:i];
  end

endmodule : gray2bin
`default_nettype wire

// File: rtl/servo_ramp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : servo_ramp_scheduler
//  Description : Time-multiplexed servo ramp scheduler. On each control tick
//                the block walks all channels, one per clock, and nudges each
//                enabled channel's PWM compare value one step toward its
//                target, clamped to [MIN_CVR, MAX_CVR].
//                Optional macro SERVO_GRAY_DECODE_EN: treat the measured
//                position lanes as Gray code and decode before subtracting.
//  Revision    : 1.0 - initial release
// ============================================================================
module servo_ramp_scheduler
  import servo_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = W_DEFAULT,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               tick,
  input  logic [NCH-1:0]     ch_en,
  input  logic [NCH*W-1:0]   cur,
  input  logic               tgt_wr,
  input  logic [CHW-1:0]     tgt_ch,
  input  logic [W-1:0]       tgt_data,
  output logic               tgt_rdy,
  output logic [NCH*W-1:0]   cvr,
  output logic               busy,
  output logic               sweep_done,
  output logic               overrun
);

  localparam logic [W-1:0]   C_MAX     = W'(MAX_CVR);
  localparam logic [W-1:0]   C_MIN     = W'(MIN_CVR);
  localparam logic [CHW-1:0] C_LAST_CH = CHW'(NCH - 1);

  state_t                  state_q, state_d;
  logic [CHW-1:0]          idx_q, idx_d;
  logic [NCH-1:0][W-1:0]   cvr_q, cvr_d;
  logic [NCH-1:0][W-1:0]   tgt_q, tgt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rdy_q, rdy_d;
  logic                    ovr_q, ovr_d;

  logic [NCH-1:0][W-1:0]   cur_arr;
  logic [W-1:0]            cur_sel;
  logic [W-1:0]            cur_bin;
  logic [W-1:0]            tgt_sel;
  logic [W-1:0]            cvr_sel;
  logic signed [W:0]       diff;
  logic                    step_up;
  logic                    step_dn;
  logic                    wr_ok;

  assign cur_arr = cur;
  assign cur_sel = cur_arr[idx_q];

`ifdef SERVO_GRAY_DECODE_EN
  gray2bin #(
    .W (W)
  ) u_gray2bin (
    .gray_in (cur_sel),
    .bin_out (cur_bin)
  );
`else
  assign cur_bin = cur_sel;
`endif

  // Shared ramp datapath for the channel currently in its slot. Both operands
  // are zero-extended by one bit so the signed difference cannot overflow.
  assign tgt_sel = tgt_q[idx_q];
  assign cvr_sel = cvr_q[idx_q];
  assign diff    = $signed({1'b0, tgt_sel}) - $signed({1'b0, cur_bin});
  assign step_up = !diff[W] && (diff != '0) && (cvr_sel < C_MAX);
  assign step_dn = diff[W] && (cvr_sel > C_MIN);

  // A write is only taken while the handshake shows ready (IDLE).
  assign wr_ok   = tgt_wr & rdy_q;

  // Next-state, datapath update and registered-output computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cvr_d   = cvr_q;
    tgt_d   = tgt_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;

    case (state_q)
      INIT: begin
        state_d = IDLE;
        for (int k = 0; k < NCH; k++) begin
          cvr_d[k] = C_MIN;
        end
        if (tick) begin
          ovr_d = 1'b1;
        end
      end

      IDLE: begin
        // The write lands on the same edge as a coincident tick, so the
        // first slot of the sweep already sees the new target.
        if (wr_ok && (int'(tgt_ch) < NCH)) begin
          tgt_d[tgt_ch] = tgt_data;
        end
        if (tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end

      SWEEP: begin
        if (tick) begin
          ovr_d = 1'b1;
        end
        if (ch_en[idx_q]) begin
          if (step_up) begin
            cvr_d[idx_q] = cvr_sel + W'(1);
          end else if (step_dn) begin
            cvr_d[idx_q] = cvr_sel - W'(1);
          end
        end
        if (idx_q == C_LAST_CH) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + CHW'(1);
        end
      end

      default: begin
        state_d = INIT;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d == SWEEP);
    rdy_d  = (state_d == IDLE);
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= INIT;
      idx_q   <= '0;
      cvr_q   <= '0;
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cvr_q   <= cvr_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cvr        = cvr_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;
  assign tgt_rdy    = rdy_q;
  assign overrun    = ovr_q;

endmodule : servo_ramp_scheduler
`default_nettype wire

// File: tb/tb_servo_ramp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_ramp_scheduler
//  Description : Directed self-checking bench for servo_ramp_scheduler.
//                Expected cvr words are queued when a tick is driven and
//                compared when sweep_done is observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_ramp_scheduler;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        tick = 1'b0;
  logic [3:0]  ch_en = 4'hF;
  logic [31:0] cur = '0;
  logic        tgt_wr = 1'b0;
  logic [1:0]  tgt_ch = '0;
  logic [7:0]  tgt_data = '0;
  logic        tgt_rdy;
  logic [31:0] cvr;
  logic        busy;
  logic        sweep_done;
  logic        overrun;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  servo_ramp_scheduler #(
    .NCH (4),
    .W   (8)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .tick       (tick),
    .ch_en      (ch_en),
    .cur        (cur),
    .tgt_wr     (tgt_wr),
    .tgt_ch     (tgt_ch),
    .tgt_data   (tgt_data),
    .tgt_rdy    (tgt_rdy),
    .cvr        (cvr),
    .busy       (busy),
    .sweep_done (sweep_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_tgt(input logic [1:0] ch, input logic [7:0] data);
    tgt_wr   = 1'b1;
    tgt_ch   = ch;
    tgt_data = data;
    @(negedge clk);
    tgt_wr   = 1'b0;
  endtask

  // Wait (bounded) for sweep_done, compare against the queued expectation,
  // then confirm the pulse lasts a single cycle.
  task automatic wait_done();
    int n = 0;
    while (sweep_done !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (sweep_done !== 1'b1) begin
      check("sweep_done_timeout", {31'd0, sweep_done}, 32'd1);
    end else begin
      done_cnt++;
      if (exp_q.size() > 0) begin
        check(tag_q.pop_front(), cvr, exp_q.pop_front());
      end
      @(negedge clk);
      check("sweep_done_one_cycle", {31'd0, sweep_done}, 32'd0);
    end
  endtask

  task automatic sweep(input string tag, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check({tag, "_busy"}, {30'd0, busy, tgt_rdy}, 32'd2);
    wait_done();
  endtask

  initial begin
    int dc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cvr", cvr, 32'h0);
    check("rst_flags", {28'd0, busy, sweep_done, tgt_rdy, overrun}, 32'h0);

    // Release: cvr 0 first, then 01 per lane with tgt_rdy high
    nrst = 1'b1;
    #1;
    check("rel_cvr0", cvr, 32'h0);
    @(negedge clk);
    check("init_cvr", cvr, 32'h01010101);
    check("init_rdy", {31'd0, tgt_rdy}, 32'd1);

    // Channel 2 ramps toward 0x80 from cur 0x10 over three ticks
    cur = {8'h00, 8'h10, 8'h00, 8'h00};
    write_tgt(2'd2, 8'h80);
    done_cnt = 0;
    sweep("ramp_t1", 32'h01020101);
    sweep("ramp_t2", 32'h01030101);
    sweep("ramp_t3", 32'h01040101);
    check("ramp_done_cnt", done_cnt, 32'd3);

    // Ramp channel 0 up to the MAX clamp
    cur = {8'h00, 8'h80, 8'h00, 8'h00};
    write_tgt(2'd0, 8'hFF);
    for (int i = 1; i <= 253; i++) begin
      sweep("up", {8'h01, 8'h04, 8'h01, 8'(1 + i)});
    end
    sweep("max_hold", 32'h010401FE);

    // Ramp down to the MIN clamp; disabled channel 3 must not move
    cur = {8'h00, 8'h80, 8'h00, 8'hFF};
    write_tgt(2'd0, 8'h00);
    write_tgt(2'd3, 8'hFF);
    ch_en = 4'b0111;
    for (int i = 1; i <= 253; i++) begin
      sweep("down", {8'h01, 8'h04, 8'h01, 8'(8'hFE - i)});
    end
    sweep("min_hold", 32'h01040101);
    write_tgt(2'd3, 8'h00);
    ch_en = 4'hF;

    // Write coincident with tick is used by that sweep; a write attempted
    // mid-sweep is refused
    exp_q.push_back(32'h01040201);
    tag_q.push_back("coincident_wr");
    tgt_wr = 1'b1; tgt_ch = 2'd1; tgt_data = 8'hFF; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; tgt_data = 8'h00;
    check("sweep_rdy_low", {31'd0, tgt_rdy}, 32'd0);
    @(negedge clk);
    tgt_wr = 1'b0;
    wait_done();
    sweep("refused_wr", 32'h01040301);

    // Overrun: second tick two cycles after the first
    check("ovr_clear", {31'd0, overrun}, 32'd0);
    exp_q.push_back(32'h01040401);
    tag_q.push_back("overrun_sweep");
    done_cnt = 0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("ovr_set", {31'd0, overrun}, 32'd1);
    wait_done();
    dc = 0;
    repeat (8) begin
      @(negedge clk);
      if (sweep_done === 1'b1) dc++;
    end
    check("ovr_one_done", done_cnt + dc, 32'd1);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);

    // Reset during channel 1's slot aborts the sweep
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("abort_cvr_now", cvr, 32'h0);
    check("abort_flags", {28'd0, busy, sweep_done, tgt_rdy, overrun}, 32'h0);
    @(negedge clk);
    check("abort_no_update", cvr, 32'h0);
    nrst = 1'b1;
    @(negedge clk);
    check("abort_reinit", cvr, 32'h01010101);
    cur = 32'h0;
    sweep("tgt_cleared", 32'h01010101);

    // Position decode path
    write_tgt(2'd0, 8'hFF);
    sweep("pre_dec1", 32'h01010102);
    sweep("pre_dec2", 32'h01010103);
    cur = {8'h00, 8'h00, 8'h00, 8'hC0};
    write_tgt(2'd0, 8'h90);
`ifdef SERVO_GRAY_DECODE_EN
    sweep("gray_up", 32'h01010104);
    write_tgt(2'd0, 8'h7F);
    sweep("gray_dec", 32'h01010103);
`else
    sweep("bin_dn", 32'h01010102);
    write_tgt(2'd0, 8'h7F);
    sweep("bin_dec", 32'h01010101);
`endif
    check("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_servo_ramp_scheduler
`default_nettype wire
